// File: rtl/sram_burst_reader.sv
// Burst read controller for the 8K x 32 SRAM: issues one read per cycle, buffers data in a small FIFO.
// Define SRAM_RD_LAST_EN to add the m_last output and its FIFO sideband bit.
module sram_burst_reader #(
  parameter int AW         = 13,
  parameter int DW         = 32,
  parameter int LW         = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          csbn,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
`ifdef SRAM_RD_LAST_EN
  output logic          m_last,
`endif
  output logic          busy,
  output logic          done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_remaining;
  logic          r_inflight;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_mem [FIFO_DEPTH];

  logic          w_cmd_fire;
  logic [CW:0]   w_occ;
  logic          w_issue;
  logic          w_last_issue;
  logic          w_push;
  logic          w_pop;

  assign w_cmd_fire   = (r_state == S_IDLE) && cmd_valid;
  // Words already buffered plus the one coming back from the SRAM must leave room for this issue.
  assign w_occ        = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue      = (r_state == S_READ) && (r_remaining != '0) && (w_occ < DEPTH_EXT);
  assign w_last_issue = w_issue && (r_remaining == LW'(1));
  assign w_push       = r_inflight;
  assign m_valid      = (r_count != '0);
  assign w_pop        = m_valid && m_ready;
  assign m_data       = m_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = (cmd_len != '0) ? S_READ : S_DONE;
      S_READ:  if (w_last_issue) w_state_next = S_DRAIN;
      // Leave as the final word is handshaken so done lands in the following cycle.
      S_DRAIN: if (!r_inflight && ((r_count == '0) || ((r_count == CW'(1)) && w_pop)))
                 w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    csbn      = ~w_issue;
    raddr     = r_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_addr      <= cmd_addr;
        r_remaining <= cmd_len;
      end else if (w_issue) begin
        r_addr      <= r_addr + AW'(1);
        r_remaining <= r_remaining - LW'(1);
      end
      r_inflight <= w_issue;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rdata;
  end

`ifdef SRAM_RD_LAST_EN
  logic r_inflight_last;
  logic r_last_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight_last <= w_last_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_last_mem[r_wptr] <= r_inflight_last;
  end

  assign m_last = m_valid && r_last_mem[r_rptr];
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_push |-> (r_count < DEPTH_CNT));

endmodule
